// File: rtl/nibble_sum_accum.sv
// Accumulates BLOCK_LEN consecutive nibble sums into a block total and hands the
// total, a sticky overflow flag and a block sequence number downstream.
module nibble_sum_accum #(
  parameter int SUM_W     = 5,
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 4,
  parameter int SATURATE  = 1,
  localparam int FILL_W   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_sum,
  output logic              in_ready,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  block_total,
  output logic              block_ovf,
  output logic [7:0]        block_seq,
  output logic [FILL_W-1:0] fill_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BLOCK_LEN - 1);

  // Returns {overflow, result}; result is clamped or wrapped per SATURATE.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [ACC_W:0] t;
    t = {1'b0, a} + (ACC_W + 1)'(b);
    if (t[ACC_W] && (SATURATE != 0)) t[ACC_W-1:0] = '1;
    return t;
  endfunction

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic               ovf, ovf_next;
  logic [FILL_W-1:0]  fill_next;
  logic [ACC_W-1:0]   total_next;
  logic               bovf_next;
  logic [7:0]         seq_next;
  logic               accept, out_ev;
  logic [ACC_W:0]     sum_p0;

  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign out_ev    = out_valid & out_ready;
  // In HOLD acc/ovf/fill_cnt are already zero, so the same adder starts the next block.
  assign sum_p0    = sat_add(acc, in_sum);

  always_comb begin
    in_ready = 1'b0;
    if (!reset && !clear) in_ready = (state == ACCUM) ? 1'b1 : out_ready;
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    ovf_next   = ovf;
    fill_next  = fill_cnt;
    total_next = block_total;
    bovf_next  = block_ovf;
    seq_next   = block_seq;
    if (clear) begin
      state_next = ACCUM;
      acc_next   = '0;
      ovf_next   = 1'b0;
      fill_next  = '0;
    end else begin
      if (out_ev) begin
        seq_next   = block_seq + 8'd1;
        state_next = ACCUM;
      end
      if (accept) begin
        if (fill_cnt == FILL_LAST) begin
          total_next = sum_p0[ACC_W-1:0];
          bovf_next  = ovf | sum_p0[ACC_W];
          acc_next   = '0;
          ovf_next   = 1'b0;
          fill_next  = '0;
          state_next = HOLD;
        end else begin
          acc_next  = sum_p0[ACC_W-1:0];
          ovf_next  = ovf | sum_p0[ACC_W];
          fill_next = fill_cnt + FILL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      acc         <= '0;
      ovf         <= 1'b0;
      fill_cnt    <= '0;
      block_total <= '0;
      block_ovf   <= 1'b0;
      block_seq   <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      ovf         <= ovf_next;
      fill_cnt    <= fill_next;
      block_total <= total_next;
      block_ovf   <= bovf_next;
      block_seq   <= seq_next;
    end
  end

endmodule

// File: tb/tb_nibble_sum_accum.sv
// Directed bench for nibble_sum_accum: a per-cycle vector table on the default
// configuration plus hand sequences for overflow modes and BLOCK_LEN=1 streaming.
module tb_nibble_sum_accum;

  logic clk = 1'b0;
  logic reset, in_valid, clear, out_ready;
  logic [4:0] in_sum;

  logic ir_a, ov_a, ovf_a; logic [11:0] tot_a; logic [7:0] seq_a; logic [1:0] fill_a;
  logic ir_s, ov_s, ovf_s; logic [5:0]  tot_s; logic [7:0] seq_s; logic [1:0] fill_s;
  logic ir_w, ov_w, ovf_w; logic [5:0]  tot_w; logic [7:0] seq_w; logic [1:0] fill_w;
  logic ir_1, ov_1, ovf_1; logic [11:0] tot_1; logic [7:0] seq_1; logic [0:0] fill_1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_sum_accum #(.SUM_W(5), .ACC_W(12), .BLOCK_LEN(4), .SATURATE(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(ir_a),
    .clear(clear), .out_valid(ov_a), .out_ready(out_ready), .block_total(tot_a),
    .block_ovf(ovf_a), .block_seq(seq_a), .fill_cnt(fill_a));

  nibble_sum_accum #(.SUM_W(5), .ACC_W(6), .BLOCK_LEN(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(ir_s),
    .clear(clear), .out_valid(ov_s), .out_ready(out_ready), .block_total(tot_s),
    .block_ovf(ovf_s), .block_seq(seq_s), .fill_cnt(fill_s));

  nibble_sum_accum #(.SUM_W(5), .ACC_W(6), .BLOCK_LEN(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(ir_w),
    .clear(clear), .out_valid(ov_w), .out_ready(out_ready), .block_total(tot_w),
    .block_ovf(ovf_w), .block_seq(seq_w), .fill_cnt(fill_w));

  nibble_sum_accum #(.SUM_W(5), .ACC_W(12), .BLOCK_LEN(1), .SATURATE(1)) dut_1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sum(in_sum), .in_ready(ir_1),
    .clear(clear), .out_valid(ov_1), .out_ready(out_ready), .block_total(tot_1),
    .block_ovf(ovf_1), .block_seq(seq_1), .fill_cnt(fill_1));

  typedef struct {
    logic        rst, clr, v;
    logic [4:0]  s;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [11:0] e_tot;
    logic        ct;
    logic [7:0]  e_seq;
    logic        e_ovf;
    logic [1:0]  e_fill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int clr, int v, int s, int ordy, int ir, int ov,
                              int tot, int ct, int seq, int ovf, int fill);
    vec_t r;
    r.rst = rst[0]; r.clr = clr[0]; r.v = v[0]; r.s = s[4:0]; r.ordy = ordy[0];
    r.e_ir = ir[0]; r.e_ov = ov[0]; r.e_tot = tot[11:0]; r.ct = ct[0];
    r.e_seq = seq[7:0]; r.e_ovf = ovf[0]; r.e_fill = fill[1:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic c, input logic v, input logic [4:0] s,
                       input logic o);
    @(negedge clk);
    reset = r; clear = c; in_valid = v; in_sum = s; out_ready = o;
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    drive(1, 0, 1, 5'd3, 1);
    chk("in_ready during reset", 32'(ir_a), 32'd0);
    drive(1, 0, 0, 5'd0, 0);

    //        rst clr v  s  or  ir ov tot ct seq ovf fill
    tbl.push_back(mk(0, 0, 1,  3, 1,  1, 0,  0, 1, 0, 0, 0)); // reset state, basic block
    tbl.push_back(mk(0, 0, 1,  5, 1,  1, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  7, 1,  1, 0,  0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1,  9, 1,  1, 0,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0,  0, 1,  1, 1, 24, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 0, 1, 0, 0)); // second block
    tbl.push_back(mk(0, 0, 1,  2, 1,  1, 0,  0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1,  3, 1,  1, 0,  0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1,  4, 1,  1, 0,  0, 0, 1, 0, 3));
    for (int k = 0; k < 5; k++)                                 // back-pressure
      tbl.push_back(mk(0, 0, 1, 2, 0,  0, 1, 10, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1,  2, 1,  1, 1, 10, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0,  0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 10, 1,  1, 0,  0, 0, 2, 0, 1)); // clear mid-block
    tbl.push_back(mk(0, 0, 1, 11, 1,  1, 0,  0, 0, 2, 0, 2));
    tbl.push_back(mk(0, 1, 1,  5, 1,  0, 0,  0, 0, 2, 0, 3));
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1,  2, 1,  1, 0,  0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1,  3, 1,  1, 0,  0, 0, 2, 0, 2));
    tbl.push_back(mk(0, 0, 1,  4, 1,  1, 0,  0, 0, 2, 0, 3));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 1, 10, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0,  0, 1,  0, 1, 10, 1, 2, 0, 0)); // clear in HOLD
    tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0,  0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1,  7, 1,  1, 0,  0, 0, 2, 0, 0)); // reset mid-block
    tbl.push_back(mk(0, 0, 1,  7, 1,  1, 0,  0, 0, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1,  7, 1,  0, 0,  0, 0, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 1, 0, 0, 0)); // reset in HOLD
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1,  1, 1,  1, 0,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 0,  0, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].s, tbl[i].ordy);
      chk($sformatf("row%0d in_ready", i), 32'(ir_a), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d out_valid", i), 32'(ov_a), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d block_seq", i), 32'(seq_a), 32'(tbl[i].e_seq));
      chk($sformatf("row%0d fill_cnt", i), 32'(fill_a), 32'(tbl[i].e_fill));
      if (tbl[i].ct) begin
        chk($sformatf("row%0d block_total", i), 32'(tot_a), 32'(tbl[i].e_tot));
        chk($sformatf("row%0d block_ovf", i), 32'(ovf_a), 32'(tbl[i].e_ovf));
      end
    end

    // Overflow: 30*4 = 120 exceeds 63
    drive(1, 0, 0, 5'd0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 5'd30, 1);
    drive(0, 0, 0, 5'd0, 1);
    chk("sat out_valid", 32'(ov_s), 32'd1);
    chk("sat block_total", 32'(tot_s), 32'd63);
    chk("sat block_ovf", 32'(ovf_s), 32'd1);
    chk("wrap out_valid", 32'(ov_w), 32'd1);
    chk("wrap block_total", 32'(tot_w), 32'd56);
    chk("wrap block_ovf", 32'(ovf_w), 32'd1);
    for (int k = 0; k < 4; k++) drive(0, 0, 1, 5'd1, 1);
    drive(0, 0, 0, 5'd0, 1);
    chk("sat clean total", 32'(tot_s), 32'd4);
    chk("sat clean ovf", 32'(ovf_s), 32'd0);
    chk("sat clean seq", 32'(seq_s), 32'd1);
    chk("wrap clean total", 32'(tot_w), 32'd4);
    chk("wrap clean ovf", 32'(ovf_w), 32'd0);
    chk("wrap clean seq", 32'(seq_w), 32'd1);

    // BLOCK_LEN=1 streaming with sequence wrap
    drive(1, 0, 0, 5'd0, 0);
    drive(0, 0, 1, 5'd1, 1);
    for (int k = 1; k <= 257; k++) begin
      drive(0, 0, 1, 5'd1, 1);
      chk($sformatf("len1 r%0d out_valid", k), 32'(ov_1), 32'd1);
      chk($sformatf("len1 r%0d block_total", k), 32'(tot_1), 32'd1);
      chk($sformatf("len1 r%0d block_seq", k), 32'(seq_1), 32'((k - 1) % 256));
      if (k == 1 || k == 257) begin
        chk($sformatf("len1 r%0d in_ready", k), 32'(ir_1), 32'd1);
        chk($sformatf("len1 r%0d fill_cnt", k), 32'(fill_1), 32'd0);
      end
    end
    drive(0, 0, 0, 5'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
